// File: rtl/fir_frame_feeder.sv
// rtl/fir_frame_feeder.sv - sample FIFO, frame pacing and result capture for a time-multiplexed FIR filter
module fir_frame_feeder #(
    parameter int WIDTH      = 24,
    parameter int TAPS       = 128,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    output logic [WIDTH-1:0]              fir_sig,
    output logic                          fir_ready,
    input  logic [WIDTH-1:0]              fir_result,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(TAPS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(TAPS - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [PW-1:0]    phase;
    logic             primed;
    logic             cap_pend;
    logic             cap_live;

    logic empty;
    logic full;
    logic boundary;
    logic slot_free;
    logic launch;
    logic push;
    logic pop;

    assign empty      = (level == '0);
    assign full       = (level == FULL_LEVEL);
    assign boundary   = (phase == LAST_PHASE);
    assign in_ready   = !full;
    assign fifo_level = level;
    assign push       = in_valid && !full;

    // Before the first launch there is no real result to protect, so the slot is free.
    assign slot_free = !out_valid || out_ready || !primed;

    always_comb begin
        fir_ready = 1'b1;
        if (boundary) begin
            fir_ready = (!empty || flush) && slot_free;
        end
    end

    assign launch  = boundary && fir_ready;
    assign pop     = launch && !empty;
    assign fir_sig = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // phase tracks the filter's read index; it only ever stops at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= LAST_PHASE;
            primed   <= 1'b0;
            cap_pend <= 1'b0;
            cap_live <= 1'b0;
        end else begin
            if (fir_ready) begin
                phase <= phase + 1'b1;
            end
            if (launch) begin
                primed <= 1'b1;
            end
            cap_pend <= launch;
            cap_live <= launch && primed;
        end
    end

    // The filter's result register moves on the launch edge, so capture one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (cap_pend && cap_live) begin
            out_data  <= fir_result;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_frame_feeder.sv
// tb/tb_fir_frame_feeder.sv - randomized bench for fir_frame_feeder against a queue-based frame model
module tb_fir_frame_feeder;

    localparam int WIDTH = 24;
    localparam int TAPS  = 128;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] fir_sig;
    logic             fir_ready;
    logic [WIDTH-1:0] fir_result = '0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [4:0]       fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_frame_feeder #(.WIDTH(WIDTH), .TAPS(TAPS), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .fir_sig    (fir_sig),
        .fir_ready  (fir_ready),
        .fir_result (fir_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level)
    );

    // Stub filter: on each frame-completing edge it presents the result of the previous frame's sample.
    logic [6:0]       stub_idx = 7'd127;
    logic [WIDTH-1:0] stub_last = '0;
    always @(posedge clk) begin
        if (rst) begin
            stub_idx <= 7'd127;
        end else if (fir_ready) begin
            stub_idx <= stub_idx + 7'd1;
            if (stub_idx == 7'd127) begin
                fir_result <= stub_last;
                stub_last  <= fir_sig;
            end
        end
    end

    logic [WIDTH-1:0] m_q[$];
    int               m_pos;
    bit               m_primed;
    bit               m_ov;
    logic [WIDTH-1:0] m_od;
    bit               m_cap;
    logic [WIDTH-1:0] m_cap_val;
    logic [WIDTH-1:0] m_prev;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_q.delete();
        m_pos    = TAPS - 1;
        m_primed = 1'b0;
        m_ov     = 1'b0;
        m_od     = '0;
        m_cap    = 1'b0;
        m_cap_val = '0;
    endtask

    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit fl, input bit ordy, input bit r);
        bit e_ir, bnd, slot, e_fr, launch;
        logic [WIDTH-1:0] val;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        rst       = r;
        #1;
        e_ir = (m_q.size() < DEPTH);
        bnd  = (m_pos == TAPS - 1);
        slot = !m_ov || ordy || !m_primed;
        e_fr = bnd ? ((m_q.size() != 0 || fl) && slot) : 1'b1;
        launch = bnd && e_fr;
        check_eq("fir_ready", 32'(fir_ready), 32'(e_fr));
        check_eq("in_ready", 32'(in_ready), 32'(e_ir));
        check_eq("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check_eq("out_valid", 32'(out_valid), 32'(m_ov));
        check_eq("out_data", 32'(out_data), 32'(m_od));
        val = (m_q.size() != 0) ? m_q[0] : '0;
        if (launch) begin
            check_eq("fir_sig", 32'(fir_sig), 32'(val));
        end
        if (r) begin
            reset_model();
        end else begin
            if (m_cap) begin
                m_ov = 1'b1;
                m_od = m_cap_val;
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
            m_cap     = launch && m_primed;
            m_cap_val = m_prev;
            if (launch) begin
                if (m_q.size() != 0) begin
                    void'(m_q.pop_front());
                end
                m_prev   = val;
                m_primed = 1'b1;
                m_pos    = 0;
            end else if (!bnd) begin
                m_pos = m_pos + 1;
            end
            if (v && e_ir) begin
                m_q.push_back(d);
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n, input bit fl, input bit ordy);
        for (int i = 0; i < n; i++) begin
            step(1'b0, '0, fl, ordy, 1'b0);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_sample();
        logic [31:0] x;
        x = $urandom;
        return x[WIDTH-1:0];
    endfunction

    initial begin
        reset_model();
        m_prev = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state, then three back-to-back samples drained with flush low.
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 24'd1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 24'd2, 1'b0, 1'b1, 1'b0);
        step(1'b1, 24'd3, 1'b0, 1'b1, 1'b0);
        idle(3 * TAPS + 10, 1'b0, 1'b1);

        // Flush pushes the last result out and then a zero.
        idle(2 * TAPS + 10, 1'b1, 1'b1);
        idle(TAPS, 1'b0, 1'b1);

        // Overfill with the output blocked so the filter stalls at the boundary.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, rnd_sample(), 1'b0, 1'b0, 1'b0);
        end
        idle(3 * TAPS, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b1);
        idle(4, 1'b0, 1'b0);
        idle(4 * TAPS, 1'b0, 1'b1);

        // Reset mid-frame with samples still queued.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, rnd_sample(), 1'b0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3 * TAPS && m_pos != 60; i++) begin
            idle(1, 1'b0, 1'b1);
        end
        check_eq("reach_phase60", 32'(m_pos), 32'd60);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, rnd_sample(), 1'b0, 1'b1, 1'b0);
        end
        idle(4 * TAPS, 1'b0, 1'b1);

        // Randomized traffic with varying input rate, flush and backpressure.
        for (int seg = 0; seg < 4; seg++) begin
            int pv, pf, pr;
            pv = (seg == 0) ? 2 : (seg == 1) ? 30 : (seg == 2) ? 1 : 60;
            pf = (seg == 2) ? 50 : 5;
            pr = (seg == 3) ? 20 : 60;
            for (int i = 0; i < 12 * TAPS; i++) begin
                step($urandom_range(0, 99) < pv, rnd_sample(),
                     $urandom_range(0, 99) < pf, $urandom_range(0, 99) < pr, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
